// File: rtl/toggle_ctrl_pkg.sv
// toggle_ctrl_pkg: shared state encoding and direction constants for the toggle counter
package toggle_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/toggle_cell.sv
// toggle_cell: single T flip-flop with synchronous active-high reset
module toggle_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk)
    if (rst) q <= 1'b0;
    else if (t) q <= ~q;
endmodule

// File: rtl/toggle_counter_ctrl.sv
// toggle_counter_ctrl: programmable up/down counter built from a bank of T flip-flop cells
module toggle_counter_ctrl
  import toggle_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  input  logic         oneshot,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         tc,
  output logic         done
);
  state_t state;
  logic [W-1:0] base, nxt, step, t;
  logic at_lim;
  assign at_lim = count == limit;
  assign step = dir == DIR_UP ? count + W'(1) : count - W'(1);
  assign busy = state == COUNT;
  assign tc = busy && at_lim;
  // The cells only ever see toggle enables; the target value is expressed as a flip mask.
  assign t = count ^ nxt;
  always_comb begin
    nxt = count;
    case (state)
      IDLE:    nxt = load ? load_val : count;
      COUNT:   nxt = stop ? count : at_lim ? (oneshot ? count : base) : step;
      DONE:    nxt = load ? load_val : start ? base : count;
      default: nxt = count;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      done  <= 1'b0;
    end else begin
      done <= state == COUNT && !stop && at_lim && oneshot;
      case (state)
        IDLE: begin
          if (load) base <= load_val;
          if (start) state <= COUNT;
        end
        COUNT:
          if (stop) state <= IDLE;
          else if (at_lim && oneshot) state <= DONE;
        DONE: begin
          if (load) base <= load_val;
          if (start) state <= COUNT;
        end
        default: state <= IDLE;
      endcase
    end
  for (genvar i = 0; i < W; i++) begin : g_cell
    toggle_cell u_cell (.clk(clk), .rst(rst), .t(t[i]), .q(count[i]));
  end
endmodule

// File: tb/tb_toggle_counter_ctrl.sv
// tb_toggle_counter_ctrl: directed vectors with a queued-expectation scoreboard for toggle_counter_ctrl
module tb_toggle_counter_ctrl;
  typedef struct packed {
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;
  } obs_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, dir = 1'b1, oneshot = 1'b1, load = 1'b0;
  logic [3:0] load_val = '0, limit = '0;
  logic [3:0] count;
  logic       busy, tc, done;
  obs_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  toggle_counter_ctrl #(.W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .oneshot(oneshot),
    .load(load), .load_val(load_val), .limit(limit),
    .count(count), .busy(busy), .tc(tc), .done(done)
  );
  always #5 clk = ~clk;
  // Expected outputs after the coming edge are queued; the monitor checks them on the falling edge.
  task automatic chk(input logic [3:0] c, input logic b, input logic t, input logic d);
    @(posedge clk);
    exp_q.push_back('{count: c, busy: b, tc: t, done: d});
    #1;
  endtask
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = '{count: count, busy: busy, tc: tc, done: done};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d t=%0t: got count=%0d busy=%b tc=%b done=%b, want count=%0d busy=%b tc=%b done=%b",
                 vectors, $time, a.count, a.busy, a.tc, a.done, e.count, e.busy, e.tc, e.done);
      end
    end
  initial begin
    #1;
    chk(0, 0, 0, 0);
    rst = 0;
    chk(0, 0, 0, 0);
    // oneshot up 3..7
    limit = 7; dir = 1; oneshot = 1; load = 1; load_val = 3;
    chk(3, 0, 0, 0);
    load = 0; start = 1;
    chk(3, 1, 0, 0);
    start = 0;
    chk(4, 1, 0, 0); chk(5, 1, 0, 0); chk(6, 1, 0, 0); chk(7, 1, 1, 0);
    chk(7, 0, 0, 1); chk(7, 0, 0, 0);
    // modulo base 2 limit 5, entered from DONE
    load = 1; load_val = 2;
    chk(2, 0, 0, 0);
    load = 0; limit = 5; oneshot = 0; start = 1;
    chk(2, 1, 0, 0);
    start = 0;
    chk(3, 1, 0, 0); chk(4, 1, 0, 0); chk(5, 1, 1, 0); chk(2, 1, 0, 0);
    chk(3, 1, 0, 0); chk(4, 1, 0, 0); chk(5, 1, 1, 0); chk(2, 1, 0, 0);
    stop = 1;
    chk(2, 0, 0, 0);
    stop = 0;
    // down wrap 1,0,15,14
    load = 1; load_val = 1; dir = 0; limit = 14; oneshot = 1;
    chk(1, 0, 0, 0);
    load = 0; start = 1;
    chk(1, 1, 0, 0);
    start = 0;
    chk(0, 1, 0, 0); chk(15, 1, 0, 0); chk(14, 1, 1, 0);
    chk(14, 0, 0, 1); chk(14, 0, 0, 0);
    // load+start from DONE, then stop/resume at 4
    load = 1; start = 1; load_val = 2; dir = 1; limit = 15;
    chk(2, 1, 0, 0);
    load = 0; start = 0;
    chk(3, 1, 0, 0); chk(4, 1, 0, 0);
    stop = 1;
    chk(4, 0, 0, 0);
    stop = 0;
    chk(4, 0, 0, 0);
    start = 1;
    chk(4, 1, 0, 0);
    start = 0;
    chk(5, 1, 0, 0);
    // load ignored in COUNT; stop beats terminal
    limit = 7; load = 1; load_val = 0;
    chk(6, 1, 0, 0);
    load = 0;
    chk(7, 1, 1, 0);
    stop = 1;
    chk(7, 0, 0, 0);
    stop = 0;
    chk(7, 0, 0, 0);
    // reset mid-count at 9
    limit = 15; start = 1;
    chk(7, 1, 0, 0);
    start = 0;
    chk(8, 1, 0, 0); chk(9, 1, 0, 0);
    rst = 1; start = 1; load = 1; load_val = 6;
    chk(0, 0, 0, 0);
    rst = 0; start = 0; load = 0;
    // base cleared by reset: modulo wraps back to 0
    limit = 3; oneshot = 0; dir = 1; start = 1;
    chk(0, 1, 0, 0);
    start = 0;
    chk(1, 1, 0, 0); chk(2, 1, 0, 0); chk(3, 1, 1, 0); chk(0, 1, 0, 0);
    stop = 1;
    chk(0, 0, 0, 0);
    stop = 0;
    // base == limit in modulo mode sits with tc high
    load = 1; load_val = 5; limit = 5;
    chk(5, 0, 0, 0);
    load = 0; start = 1;
    chk(5, 1, 1, 0);
    start = 0;
    chk(5, 1, 1, 0); chk(5, 1, 1, 0);
    // up wrap 15 -> 0
    stop = 1;
    chk(5, 0, 0, 0);
    stop = 0; load = 1; load_val = 14; limit = 1; oneshot = 1;
    chk(14, 0, 0, 0);
    load = 0; start = 1;
    chk(14, 1, 0, 0);
    start = 0;
    chk(15, 1, 0, 0); chk(0, 1, 0, 0); chk(1, 1, 1, 0); chk(1, 0, 0, 1);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
